// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word requests to instruction memory,
// hands instructions to the fetch/decode register, buffers one instruction
// across decode stalls and quietly drains a request made stale by a redirect.
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  valid_f,
  output logic [DATA_WIDTH-1:0] read_data_f,
  output logic [DATA_WIDTH-1:0] PC_f,
  output logic [DATA_WIDTH-1:0] PCPlus4_f
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_e;

  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH-1:0]   buf_q;
  logic [DATA_WIDTH-1:0]   drop_addr_q;
  logic [DATA_WIDTH-1:0]   target;
  logic [DATA_WIDTH-1:0]   pc_plus4;

  // Word-aligned redirect target and sequential successor
  always_comb begin
    target   = redirect_pc & ALIGN_MASK;
    pc_plus4 = pc_q + PC_STEP;
  end

  // Memory request and decode-side presentation; reset masks req/valid
  always_comb begin
    imem_req    = rst_n && (state_q != HOLD);
    imem_addr   = (state_q == DROP) ? drop_addr_q : pc_q;
    valid_f     = rst_n && !redirect &&
                  (((state_q == FETCH) && imem_ack) || (state_q == HOLD));
    read_data_f = (state_q == HOLD) ? buf_q : imem_rdata;
    PC_f        = pc_q;
    PCPlus4_f   = pc_plus4;
  end

  // Fetch FSM: redirect wins over ack and en in every state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC & ALIGN_MASK;
      buf_q       <= '0;
      drop_addr_q <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (redirect) begin
            pc_q <= target;
            if (!imem_ack) begin
              // Request still in flight: remember its address so the
              // bus sees a stable request until the stale ack arrives.
              drop_addr_q <= pc_q;
              state_q     <= DROP;
            end
          end else if (imem_ack) begin
            if (en) begin
              pc_q <= pc_plus4;
            end else begin
              buf_q   <= imem_rdata;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_q    <= target;
            state_q <= FETCH;
          end else if (en) begin
            pc_q    <= pc_plus4;
            state_q <= FETCH;
          end
        end
        DROP: begin
          if (redirect) pc_q <= target;
          if (imem_ack) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-computed vectors covering streaming,
// decode stall buffering, redirect in each state, PC wrap and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, en, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, valid_f;
  logic [31:0] imem_addr, read_data_f, PC_f, PCPlus4_f;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .valid_f    (valid_f),
    .read_data_f(read_data_f),
    .PC_f       (PC_f),
    .PCPlus4_f  (PCPlus4_f)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs for the current cycle and let combinational outputs settle
  task automatic drv(input logic r, input logic e, input logic rd, input logic [31:0] rpc,
                     input logic a, input logic [31:0] d);
    rst_n = r; en = e; redirect = rd; redirect_pc = rpc; imem_ack = a; imem_rdata = d;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", valid_f, 1'b0);
    tick();
    chk("rst_pc", PC_f, 32'h0);
    tick();

    // Zero-wait streaming from RESET_PC
    for (int unsigned i = 0; i < 4; i++) begin
      drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hA000_0000 | (i * 4));
      chk("str_req", imem_req, 1'b1);
      chk("str_addr", imem_addr, i * 4);
      chk("str_valid", valid_f, 1'b1);
      chk("str_pc", PC_f, i * 4);
      chk("str_pc4", PCPlus4_f, i * 4 + 4);
      chk("str_data", read_data_f, 32'hA000_0000 | (i * 4));
      tick();
    end

    // Ack at 0x10 while decode stalls: buffered in HOLD
    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    chk("st_addr", imem_addr, 32'h10);
    chk("st_valid", valid_f, 1'b1);
    chk("st_data", read_data_f, 32'hDEAD_BEEF);
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      drv(1'b1, (i == 2), 1'b0, 32'h0, 1'b0, 32'h1111_1111);
      chk("hold_req", imem_req, 1'b0);
      chk("hold_valid", valid_f, 1'b1);
      chk("hold_pc", PC_f, 32'h10);
      chk("hold_data", read_data_f, 32'hDEAD_BEEF);
      tick();
    end
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("post_hold_req", imem_req, 1'b1);
    chk("post_hold_addr", imem_addr, 32'h14);

    // Advance to 0x20
    for (int unsigned i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      tick();
    end

    // Redirect with request outstanding at 0x20: drained in DROP
    drv(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("dr0_addr", imem_addr, 32'h20);
    chk("dr0_valid", valid_f, 1'b0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("dr1_req", imem_req, 1'b1);
    chk("dr1_addr", imem_addr, 32'h20);
    chk("dr1_valid", valid_f, 1'b0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    chk("dr2_addr", imem_addr, 32'h20);
    chk("dr2_valid", valid_f, 1'b0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("dr_next_addr", imem_addr, 32'h100);

    // Second redirect while in DROP: last target wins, low bits dropped
    drv(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    drv(1'b1, 1'b1, 1'b1, 32'h402, 1'b0, 32'h0);
    chk("dd_addr", imem_addr, 32'h100);
    chk("dd_pc", PC_f, 32'h300);
    tick();
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("dd_valid", valid_f, 1'b0);
    chk("dd_addr2", imem_addr, 32'h100);
    tick();
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("dd_next_addr", imem_addr, 32'h400);

    // Redirect with same-cycle ack stays in FETCH
    drv(1'b1, 1'b1, 1'b1, 32'h42, 1'b1, 32'h0);
    chk("ra_valid", valid_f, 1'b0);
    tick();
    drv(1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h7777_7777);
    chk("ra_addr", imem_addr, 32'h40);
    chk("ra_valid2", valid_f, 1'b0);
    tick();
    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
    chk("ra_next_addr", imem_addr, 32'h200);
    chk("ra_next_valid", valid_f, 1'b1);
    tick();

    // Redirect in HOLD discards buffer
    drv(1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
    chk("rh_req", imem_req, 1'b0);
    chk("rh_valid", valid_f, 1'b0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    chk("rh_addr", imem_addr, 32'h500);
    chk("rh_data", read_data_f, 32'h1234_5678);
    chk("rh_valid2", valid_f, 1'b1);
    tick();

    // PC wrap at top of address space
    drv(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0BAD_0BAD);
    chk("wr_pc", PC_f, 32'hFFFF_FFFC);
    chk("wr_pc4", PCPlus4_f, 32'h0);
    chk("wr_valid", valid_f, 1'b1);
    tick();
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("wr_next_addr", imem_addr, 32'h0);
    tick();

    // Reset while request at 0x4 is waiting
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rw_addr", imem_addr, 32'h4);
    drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("rw_req", imem_req, 1'b0);
    chk("rw_valid", valid_f, 1'b0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rr_req", imem_req, 1'b1);
    chk("rr_addr", imem_addr, 32'h0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h600D_600D);
    chk("rr_valid", valid_f, 1'b1);
    chk("rr_data", read_data_f, 32'h600D_600D);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the address, instruction and PC.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: decode-side stall; 0 means stall, 1 means the fetch/decode register accepts this cycle.
REQ-006 The block SHALL have port redirect, input, 1 bit: branch/jump flush request.
REQ-007 The block SHALL have port redirect_pc, input, DATA_WIDTH bits: the new fetch target, sampled when redirect=1.
REQ-008 The block SHALL have port imem_req, output, 1 bit: instruction memory/cache request.
REQ-009 The block SHALL have port imem_addr, output, DATA_WIDTH bits: the request address.
REQ-010 The block SHALL have port imem_ack, input, 1 bit: request complete; imem_rdata is valid in the same cycle.
REQ-011 The block SHALL have port imem_rdata, input, DATA_WIDTH bits: the returned instruction word.
REQ-012 The block SHALL have port valid_f, output, 1 bit: an instruction is presented to the fetch/decode register.
REQ-013 The block SHALL have ports read_data_f, PC_f and PCPlus4_f, each output, DATA_WIDTH bits: the instruction, its address, and address+4.

Function
REQ-014 The block SHALL implement the states FETCH (request outstanding), HOLD (instruction buffered, awaiting en) and DROP (stale request outstanding after a redirect).
REQ-015 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-016 In DROP, imem_req SHALL be 1 and imem_addr SHALL equal drop_addr.
REQ-017 In HOLD, imem_req SHALL be 0.
REQ-018 Once raised, imem_req and imem_addr SHALL remain stable until imem_ack.
REQ-019 valid_f SHALL be 1 when (FETCH and imem_ack and !redirect) or (HOLD and !redirect), and SHALL be 0 otherwise.
REQ-020 read_data_f SHALL equal imem_rdata in FETCH and the buffer in HOLD; PC_f SHALL equal pc; PCPlus4_f SHALL equal pc+4 modulo 2^DATA_WIDTH.
REQ-021 In FETCH with imem_ack, en=1 and !redirect, the instruction SHALL be handed off, pc SHALL become pc+4 and the state SHALL remain FETCH, giving one instruction per cycle on zero-wait acks.
REQ-022 In FETCH with imem_ack, en=0 and !redirect, imem_rdata SHALL be captured into the buffer, pc SHALL be unchanged and the state SHALL become HOLD.
REQ-023 In FETCH with !imem_ack and !redirect, there SHALL be no change.
REQ-024 In HOLD with en=1 and !redirect, the instruction SHALL be handed off, pc SHALL become pc+4 and the state SHALL become FETCH.
REQ-025 In HOLD with en=0, the state SHALL remain HOLD with the buffer and pc stable.
REQ-026 redirect SHALL take priority over en and imem_ack in every state.
REQ-027 On redirect in FETCH with imem_ack, the data SHALL be discarded, pc SHALL become redirect_pc and the state SHALL remain FETCH.
REQ-028 On redirect in FETCH with !imem_ack, drop_addr SHALL become pc, pc SHALL become redirect_pc and the state SHALL become DROP.
REQ-029 On redirect in HOLD, the buffer SHALL be discarded, pc SHALL become redirect_pc and the state SHALL become FETCH.
REQ-030 In DROP, the returned data SHALL be discarded and valid_f SHALL be 0; on imem_ack the state SHALL become FETCH.
REQ-031 A redirect in DROP SHALL overwrite pc (last target wins) while the state stays DROP until imem_ack.
REQ-032 redirect_pc[1:0] SHALL be ignored and pc[1:0] SHALL always be 0.
REQ-033 pc+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-034 When rst_n=0 at posedge clk: pc SHALL become RESET_PC, the state SHALL become FETCH, and the buffer and drop_addr SHALL become 0.
REQ-035 While rst_n=0, imem_req and valid_f SHALL be forced to 0 combinationally.
REQ-036 Reset mid-request SHALL abandon the outstanding request, with no DROP state.
REQ-037 The first request SHALL appear in the first cycle with rst_n=1, with imem_addr=RESET_PC.

Verification
REQ-038 Reset release, imem_ack tied 1, en=1 -> PC_f = 0, 4, 8, 12 on consecutive cycles, with valid_f=1 every cycle.
REQ-039 Ack at addr 0x10 with en=0 for 3 cycles, then en=1 -> HOLD; valid_f=1, PC_f=0x10 and read_data_f stable for 4 cycles; imem_req=0 during HOLD; the next request goes to 0x14.
REQ-040 Request at 0x20 unacked, redirect to 0x100, ack 2 cycles later -> imem_addr stays 0x20 until the ack with valid_f=0 throughout; the next request goes to 0x100.
REQ-041 redirect to 0x200 with the same-cycle ack at 0x40 -> valid_f=0 that cycle; the next cycle requests 0x200; redirect in HOLD -> the buffer is dropped and the fetch goes to the target.
REQ-042 pc=0xFFFF_FFFC handed off -> PCPlus4_f=0 and the next fetch goes to 0x0; rst_n=0 during WAIT -> the next cycle has imem_req=0 and valid_f=0, then the fetch restarts at RESET_PC.
